// File: rtl/board_datapath_pkg.sv
// Shared chess definitions: piece codes, datapath FSM states, operand record,
// board address packing and the starting-board lookup.
package board_datapath_pkg;

  typedef logic [3:0] piece_t;

  localparam piece_t EMPTY        = 4'd0;
  localparam piece_t W_PAWN       = 4'd1;
  localparam piece_t W_ROOK       = 4'd2;
  localparam piece_t W_KNIGHT     = 4'd3;
  localparam piece_t W_BISHOP     = 4'd4;
  localparam piece_t W_QUEEN      = 4'd5;
  localparam piece_t W_KING       = 4'd6;
  localparam piece_t BLACK_OFFSET = 4'd6;
  localparam piece_t B_PAWN       = W_PAWN + BLACK_OFFSET;

  typedef enum logic [2:0] {
    IDLE,
    INIT_WR,
    INIT_DONE,
    MV_CLEAR,
    MV_WRITE,
    MV_DONE
  } dp_state_t;

  typedef struct packed {
    piece_t     piece;
    logic [2:0] origin_x;
    logic [2:0] origin_y;
    logic [2:0] dest_x;
    logic [2:0] dest_y;
  } move_t;

  function automatic logic [5:0] cell_addr(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

  function automatic piece_t back_rank(input logic [2:0] x);
    case (x)
      3'd0, 3'd7: return W_ROOK;
      3'd1, 3'd6: return W_KNIGHT;
      3'd2, 3'd5: return W_BISHOP;
      3'd3:       return W_QUEEN;
      default:    return W_KING;
    endcase
  endfunction

  function automatic piece_t start_piece(input logic [5:0] addr);
    case (addr[5:3])
      3'd0:    return back_rank(addr[2:0]);
      3'd1:    return W_PAWN;
      3'd6:    return B_PAWN;
      3'd7:    return back_rank(addr[2:0]) + BLACK_OFFSET;
      default: return EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/board_datapath_if.sv
// Request / board-RAM bundle between the game controller and the board datapath.
interface board_datapath_if;
  import board_datapath_pkg::*;

  logic       initialize_board;
  logic       move_piece;
  piece_t     piece_to_move;
  logic [2:0] origin_x;
  logic [2:0] origin_y;
  logic [2:0] destination_x;
  logic [2:0] destination_y;
  logic       mem_grant;
  logic [5:0] mem_address;
  piece_t     mem_data;
  logic       mem_wren;
  logic       initialize_complete;
  logic       move_complete;
  logic       busy;

  modport master (
    output initialize_board, move_piece, piece_to_move,
           origin_x, origin_y, destination_x, destination_y, mem_grant,
    input  mem_address, mem_data, mem_wren,
           initialize_complete, move_complete, busy
  );

  modport slave (
    input  initialize_board, move_piece, piece_to_move,
           origin_x, origin_y, destination_x, destination_y, mem_grant,
    output mem_address, mem_data, mem_wren,
           initialize_complete, move_complete, busy
  );
endinterface

// File: rtl/board_datapath_init_rom.sv
// Combinational starting-board lookup: board address in, piece code out.
module board_init_rom
  import board_datapath_pkg::*;
(
  input  logic [5:0] addr,
  output piece_t     code
);
  assign code = start_piece(addr);
endmodule

// File: rtl/board_datapath.sv
// Board datapath: writes the starting position into board RAM or executes a
// move as clear-origin then write-destination, stalling whenever the RAM is not granted.
module board_datapath
  import board_datapath_pkg::*;
(
  input  logic clk,
  input  logic reset,
  board_datapath_if.slave bus
);

  dp_state_t  state, state_next;
  logic [5:0] cell_cnt, cell_cnt_next;
  move_t      move_q, move_next;
  piece_t     rom_code;

  board_init_rom u_rom (
    .addr (cell_cnt),
    .code (rom_code)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cell_cnt <= '0;
      move_q   <= '0;
    end else begin
      state    <= state_next;
      cell_cnt <= cell_cnt_next;
      move_q   <= move_next;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // forgets one would otherwise infer a latch.
    state_next              = state;
    cell_cnt_next           = cell_cnt;
    move_next               = move_q;
    bus.mem_address         = '0;
    bus.mem_data            = EMPTY;
    bus.mem_wren            = 1'b0;
    bus.initialize_complete = 1'b0;
    bus.move_complete       = 1'b0;

    case (state)
      IDLE: begin
        // Init takes priority; a simultaneous move request is dropped.
        if (bus.initialize_board) begin
          state_next    = INIT_WR;
          cell_cnt_next = '0;
        end else if (bus.move_piece) begin
          state_next = MV_CLEAR;
          move_next  = '{piece:    bus.piece_to_move,
                         origin_x: bus.origin_x,
                         origin_y: bus.origin_y,
                         dest_x:   bus.destination_x,
                         dest_y:   bus.destination_y};
        end
      end

      INIT_WR: begin
        bus.mem_wren    = bus.mem_grant;
        bus.mem_address = cell_cnt;
        bus.mem_data    = rom_code;
        if (bus.mem_grant) begin
          cell_cnt_next = cell_cnt + 6'd1;
          if (cell_cnt == 6'd63) state_next = INIT_DONE;
        end
      end

      INIT_DONE: begin
        bus.initialize_complete = 1'b1;
        state_next              = IDLE;
      end

      MV_CLEAR: begin
        bus.mem_wren    = bus.mem_grant;
        bus.mem_address = cell_addr(move_q.origin_x, move_q.origin_y);
        bus.mem_data    = EMPTY;
        if (bus.mem_grant) state_next = MV_WRITE;
      end

      MV_WRITE: begin
        bus.mem_wren    = bus.mem_grant;
        bus.mem_address = cell_addr(move_q.dest_x, move_q.dest_y);
        bus.mem_data    = move_q.piece;
        if (bus.mem_grant) state_next = MV_DONE;
      end

      MV_DONE: begin
        bus.move_complete = 1'b1;
        state_next        = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_board_datapath.sv
// Self-checking bench for board_datapath: directed vector table, hand-written
// stall/abort/busy sequences and randomized operations against a board model.
module tb_board_datapath;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  board_datapath_if bus ();

  board_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  // Monitor-owned logs (written only by the monitor process).
  logic [5:0] wa [$];
  logic [3:0] wd [$];
  int         wc [$];
  int         bad_wren      = 0;
  int         init_done_cnt = 0;
  int         move_done_cnt = 0;
  int         init_done_cyc = 0;
  int         move_done_cyc = 0;
  logic [3:0] ram [64]      = '{default: 4'd0};

  // Stimulus/model state (written only by the main process).
  logic [3:0] ref_board [64] = '{default: 4'd0};
  int         grant_pct = 100;
  int         hold_low  = 0;
  bit         drop_at30 = 1'b0;
  bit         dropped   = 1'b0;
  int         op_base   = 0;

  always @(posedge clk) cyc_no++;

  always @(negedge clk) begin
    if (bus.mem_wren) begin
      wa.push_back(bus.mem_address);
      wd.push_back(bus.mem_data);
      wc.push_back(cyc_no);
      ram[bus.mem_address] = bus.mem_data;
      if (!bus.mem_grant) bad_wren++;
    end
    if (bus.initialize_complete) begin
      init_done_cnt++;
      init_done_cyc = cyc_no;
    end
    if (bus.move_complete) begin
      move_done_cnt++;
      move_done_cyc = cyc_no;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starting position straight from the piece-code rules.
  function automatic logic [3:0] start_code(input int a);
    logic [3:0] back [8];
    int x;
    int y;
    back = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd4, 4'd3, 4'd2};
    x = a % 8;
    y = a / 8;
    if (y == 0) return back[x];
    if (y == 1) return 4'd1;
    if (y == 6) return 4'd7;
    if (y == 7) return back[x] + 4'd6;
    return 4'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.initialize_board = 1'b0;
    bus.move_piece       = 1'b0;
    if (drop_at30 && !dropped && wa.size() > op_base && wa[wa.size()-1] == 6'd30) begin
      hold_low = 10;
      dropped  = 1'b1;
    end
    if (hold_low > 0) begin
      bus.mem_grant = 1'b0;
      hold_low--;
    end else begin
      bus.mem_grant = (int'($urandom_range(99)) < grant_pct);
    end
  endtask

  task automatic run_op(input string tag, input bit ini, input bit mv, input logic [3:0] pc,
                        input logic [2:0] ox, input logic [2:0] oy,
                        input logic [2:0] dx, input logic [2:0] dy,
                        input int pct, input int noise, input int exp_lat,
                        output int lat, output int nw);
    logic [5:0] ea [$];
    logic [3:0] ed [$];
    bit exp_init = 1'b0;
    bit exp_move = 1'b0;
    int req_cyc, n, id0, md0, bw0, o, d, done_cyc;

    if (ini) begin
      exp_init = 1'b1;
      for (int a = 0; a < 64; a++) begin
        ea.push_back(6'(a));
        ed.push_back(start_code(a));
        ref_board[a] = start_code(a);
      end
    end else if (mv) begin
      exp_move = 1'b1;
      o = int'(oy) * 8 + int'(ox);
      d = int'(dy) * 8 + int'(dx);
      ea.push_back(6'(o)); ed.push_back(4'd0);
      ea.push_back(6'(d)); ed.push_back(pc);
      ref_board[o] = 4'd0;
      ref_board[d] = pc;
    end

    grant_pct = pct;
    dropped   = 1'b0;
    op_base   = wa.size();
    id0 = init_done_cnt;
    md0 = move_done_cnt;
    bw0 = bad_wren;

    step();
    bus.piece_to_move    = pc;
    bus.origin_x         = ox;
    bus.origin_y         = oy;
    bus.destination_x    = dx;
    bus.destination_y    = dy;
    bus.initialize_board = ini;
    bus.move_piece       = mv;
    req_cyc = cyc_no;

    n = 0;
    do begin
      step();
      n++;
      // Requests issued while busy must be ignored, operands included.
      if (noise != 0 && bus.busy && (noise == 2 || $urandom_range(3) == 0)) begin
        bus.piece_to_move = 4'($urandom_range(15));
        bus.origin_x      = 3'($urandom_range(7));
        bus.origin_y      = 3'($urandom_range(7));
        bus.destination_x = 3'($urandom_range(7));
        bus.destination_y = 3'($urandom_range(7));
        if (noise == 1 && $urandom_range(1) == 0) bus.initialize_board = 1'b1;
        else                                      bus.move_piece       = 1'b1;
      end
    end while ((init_done_cnt - id0) + (move_done_cnt - md0) == 0 && n < 3000);

    check({tag, " done_within_budget"}, 32'(n < 3000), 32'd1);
    repeat (4) step();

    nw = wa.size() - op_base;
    check({tag, " write_count"}, 32'(nw), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < nw; i++)
      check($sformatf("%s write%0d addr_data", tag, i),
            32'({wa[op_base+i], wd[op_base+i]}), 32'({ea[i], ed[i]}));
    check({tag, " init_complete_pulses"}, 32'(init_done_cnt - id0), 32'(exp_init));
    check({tag, " move_complete_pulses"}, 32'(move_done_cnt - md0), 32'(exp_move));
    check({tag, " wren_without_grant"}, 32'(bad_wren - bw0), 32'd0);

    done_cyc = exp_init ? init_done_cyc : move_done_cyc;
    lat = done_cyc - req_cyc;
    if (nw > 0)
      check({tag, " done_after_last_write"}, 32'(done_cyc), 32'(wc[wa.size()-1] + 1));
    if (exp_lat >= 0)
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  typedef struct {
    bit         ini;
    bit         mv;
    logic [3:0] pc;
    logic [2:0] ox, oy, dx, dy;
    int         exp_lat;
    int         exp_writes;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int lat, nw, n, rst_cyc, late, id0;

    reset                = 1'b1;
    bus.initialize_board = 1'b0;
    bus.move_piece       = 1'b0;
    bus.piece_to_move    = 4'd0;
    bus.origin_x         = 3'd0;
    bus.origin_y         = 3'd0;
    bus.destination_x    = 3'd0;
    bus.destination_y    = 3'd0;
    bus.mem_grant        = 1'b1;
    repeat (3) step();

    @(negedge clk);
    check("reset busy",         32'(bus.busy),                32'd0);
    check("reset mem_wren",     32'(bus.mem_wren),            32'd0);
    check("reset mem_address",  32'(bus.mem_address),         32'd0);
    check("reset mem_data",     32'(bus.mem_data),            32'd0);
    check("reset init_done",    32'(bus.initialize_complete), 32'd0);
    check("reset move_done",    32'(bus.move_complete),       32'd0);
    step();
    reset = 1'b0;

    // Continuous grant: init done 65 clocks after the request cycle (the 66th
    // cycle counting the request as cycle 1), move done 3 clocks after.
    vecs[0] = '{1'b1, 1'b0, 4'd0,  3'd0, 3'd0, 3'd0, 3'd0, 65, 64};
    vecs[1] = '{1'b0, 1'b1, 4'd1,  3'd4, 3'd1, 3'd4, 3'd3,  3,  2};
    vecs[2] = '{1'b1, 1'b1, 4'd3,  3'd1, 3'd0, 3'd2, 3'd2, 65, 64};
    vecs[3] = '{1'b0, 1'b1, 4'd12, 3'd7, 3'd7, 3'd0, 3'd0,  3,  2};
    vecs[4] = '{1'b0, 1'b1, 4'd9,  3'd1, 3'd7, 3'd2, 3'd5,  3,  2};
    vecs[5] = '{1'b0, 1'b1, 4'd5,  3'd2, 3'd2, 3'd2, 3'd2,  3,  2};
    vecs[6] = '{1'b0, 1'b1, 4'd0,  3'd0, 3'd1, 3'd6, 3'd6,  3,  2};

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].ini, vecs[i].mv, vecs[i].pc,
             vecs[i].ox, vecs[i].oy, vecs[i].dx, vecs[i].dy,
             100, 0, vecs[i].exp_lat, lat, nw);
      check($sformatf("vec%0d table_writes", i), 32'(nw), 32'(vecs[i].exp_writes));
      if (i == 0 && nw == 64) begin
        check("init addr4 king",        32'(wd[op_base+4]),  32'd6);
        check("init addr60 black_king", 32'(wd[op_base+60]), 32'd12);
        check("init addr20 empty",      32'(wd[op_base+20]), 32'd0);
      end
      if (i == 1 && nw == 2) begin
        check("pawn move clear addr", 32'(wa[op_base]),   32'd12);
        check("pawn move dest addr",  32'(wa[op_base+1]), 32'd28);
        check("pawn move dest data",  32'(wd[op_base+1]), 32'd1);
      end
    end

    // Grant withdrawn for 10 cycles right after address 30 is written.
    drop_at30 = 1'b1;
    run_op("grant_drop", 1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 100, 0, 75, lat, nw);
    drop_at30 = 1'b0;
    if (nw == 64) begin
      check("grant_drop next addr", 32'(wa[op_base+31]), 32'd31);
      check("grant_drop gap",       32'(wc[op_base+31] - wc[op_base+30]), 32'd11);
    end

    // Same-square move with a second request hammered while busy.
    run_op("busy_ignore", 1'b0, 1'b1, 4'd5, 3'd3, 3'd3, 3'd3, 3'd3, 100, 2, 3, lat, nw);
    check("busy_ignore addr27", 32'(ram[27]), 32'd5);

    // Reset during init, just after address 40 is written.
    grant_pct = 100;
    op_base   = wa.size();
    id0       = init_done_cnt;
    step();
    bus.initialize_board = 1'b1;
    n = 0;
    while (!(wa.size() > op_base && wa[wa.size()-1] == 6'd40) && n < 200) begin
      step();
      n++;
    end
    check("abort reached addr40", 32'(n < 200), 32'd1);
    reset   = 1'b1;
    rst_cyc = cyc_no;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort busy",        32'(bus.busy),                32'd0);
    check("abort mem_wren",    32'(bus.mem_wren),            32'd0);
    check("abort mem_address", 32'(bus.mem_address),         32'd0);
    check("abort mem_data",    32'(bus.mem_data),            32'd0);
    check("abort init_done",   32'(bus.initialize_complete), 32'd0);
    repeat (80) step();
    late = 0;
    for (int i = op_base; i < wa.size(); i++) if (wc[i] > rst_cyc) late++;
    check("abort writes_after_reset", 32'(late), 32'd0);
    check("abort no_done_pulse", 32'(init_done_cnt - id0), 32'd0);
    for (int a = 0; a <= 41; a++) ref_board[a] = start_code(a);
    run_op("restart_init", 1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 100, 0, 65, lat, nw);

    // Randomized operations, random grant density, spurious requests while busy.
    for (int k = 0; k < 25; k++) begin
      bit ini;
      int pct;
      ini = ($urandom_range(7) == 0);
      pct = ($urandom_range(3) == 0) ? 100 : int'($urandom_range(30, 99));
      run_op($sformatf("rand%0d", k), ini, !ini, 4'($urandom_range(12)),
             3'($urandom_range(7)), 3'($urandom_range(7)),
             3'($urandom_range(7)), 3'($urandom_range(7)),
             pct, 1, (pct == 100) ? (ini ? 65 : 3) : -1, lat, nw);
    end

    for (int a = 0; a < 64; a++)
      check($sformatf("final board cell%0d", a), 32'(ram[a]), 32'(ref_board[a]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
